// File: rtl/fft_in_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fft_in_reorder                                                |
// | Purpose  : Ping-pong frame buffer feeding the FFT core; optional macro    |
// |            FFT_REORDER_BITREV_EN replays frames in bit-reversed order.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fft_in_reorder #(
  parameter int  DATA_WIDTH = 16,
  parameter int  N_POINTS   = 8,
  localparam int LOG2N      = $clog2(N_POINTS)
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_re,
  input  logic signed [DATA_WIDTH-1:0] in_im,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_re,
  output logic signed [DATA_WIDTH-1:0] out_im,
  output logic [LOG2N-1:0]             out_index,
  output logic                         out_last
);

  localparam logic [LOG2N-1:0] C_LAST_IDX = LOG2N'(N_POINTS - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  bank_state_t                  r_bank_state [2];
  bank_state_t                  w_bank_state_nxt [2];
  logic signed [DATA_WIDTH-1:0] r_mem_re [2][N_POINTS];
  logic signed [DATA_WIDTH-1:0] r_mem_im [2][N_POINTS];
  logic                         r_wr_bank;
  logic                         r_rd_bank;
  logic [LOG2N-1:0]             r_wr_cnt;
  logic [LOG2N-1:0]             r_rd_cnt;
  logic [1:0]                   w_full;
  logic [LOG2N-1:0]             w_rd_addr;
  logic                         w_in_acc;
  logic                         w_out_acc;
  logic                         w_wr_last;
  logic                         w_rd_last;

  // A bank holds a complete frame from its last write until its last read.
  assign w_full[0] = (r_bank_state[0] == BANK_FULL) || (r_bank_state[0] == BANK_DRAINING);
  assign w_full[1] = (r_bank_state[1] == BANK_FULL) || (r_bank_state[1] == BANK_DRAINING);

  assign in_ready  = !w_full[r_wr_bank];
  assign out_valid = w_full[r_rd_bank];
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;
  assign w_wr_last = w_in_acc && (r_wr_cnt == C_LAST_IDX);
  assign w_rd_last = w_out_acc && (r_rd_cnt == C_LAST_IDX);

`ifdef FFT_REORDER_BITREV_EN
  always_comb begin
    w_rd_addr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      w_rd_addr[i] = r_rd_cnt[LOG2N-1-i];
    end
  end
`else
  assign w_rd_addr = r_rd_cnt;
`endif

  assign out_index = w_rd_addr;
  assign out_re    = r_mem_re[r_rd_bank][w_rd_addr];
  assign out_im    = r_mem_im[r_rd_bank][w_rd_addr];
  assign out_last  = out_valid && (r_rd_cnt == C_LAST_IDX);

  // Write and read never target the same bank in one cycle: the write bank
  // is never full and the read bank only advances when full.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_state_nxt[b] = r_bank_state[b];
      if (w_in_acc && (r_wr_bank == 1'(b))) begin
        w_bank_state_nxt[b] = w_wr_last ? BANK_FULL : BANK_FILLING;
      end else if (w_out_acc && (r_rd_bank == 1'(b))) begin
        w_bank_state_nxt[b] = w_rd_last ? BANK_EMPTY : BANK_DRAINING;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_bank_state[0] <= BANK_EMPTY;
      r_bank_state[1] <= BANK_EMPTY;
    end else begin
      r_bank_state[0] <= w_bank_state_nxt[0];
      r_bank_state[1] <= w_bank_state_nxt[1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
    end else begin
      if (w_in_acc) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end
      end
      if (w_out_acc) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_rd_last) begin
          r_rd_cnt  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N_POINTS; k++) begin
          r_mem_re[b][k] <= '0;
          r_mem_im[b][k] <= '0;
        end
      end
    end else if (w_in_acc) begin
      r_mem_re[r_wr_bank][r_wr_cnt] <= in_re;
      r_mem_im[r_wr_bank][r_wr_cnt] <= in_im;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_in_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fft_in_reorder                                             |
// | Purpose  : Self-checking bench for fft_in_reorder (honours the            |
// |            FFT_REORDER_BITREV_EN macro for expected output order).        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_fft_in_reorder;

  localparam int DW = 16;
  localparam int NP = 8;

  logic                 clk = 1'b0;
  logic                 arst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_last;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [2:0]           out_index;

  int n_vec = 0;
  int n_err = 0;
  int perm [NP];

  // Scoreboard state
  logic signed [DW-1:0] fr_re [NP];
  logic signed [DW-1:0] fr_im [NP];
  int                   fill;
  logic signed [DW-1:0] q_re [$];
  logic signed [DW-1:0] q_im [$];
  int                   q_idx [$];
  int                   out_pos;
  int                   out_count;
  logic                 prev_stall;
  logic signed [DW-1:0] prev_re, prev_im;
  logic [2:0]           prev_idx;
  logic                 prev_last;

  typedef struct {
    logic                 in_valid;
    logic signed [DW-1:0] in_re;
    logic                 out_ready;
    logic                 exp_in_ready;
    logic                 exp_out_valid;
    logic signed [DW-1:0] exp_re;
    logic [2:0]           exp_idx;
    logic                 exp_last;
  } vec_t;

  vec_t tbl [17];

  fft_in_reorder #(.DATA_WIDTH(DW), .N_POINTS(NP)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic sb_clear();
    fill = 0;
    out_pos = 0;
    out_count = 0;
    prev_stall = 1'b0;
    q_re.delete();
    q_im.delete();
    q_idx.delete();
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Samples the cycle's handshake just after the inputs were driven.
  task automatic sb_sample();
    logic signed [DW-1:0] e_re, e_im;
    int                   e_idx;
    logic                 e_last;
    if (prev_stall) begin
      n_vec++;
      if (!out_valid || out_re !== prev_re || out_im !== prev_im ||
          out_index !== prev_idx || out_last !== prev_last) begin
        n_err++;
        $display("FAIL stall_hold: valid=%0b re=%0d im=%0d idx=%0d last=%0b, required valid=1 re=%0d im=%0d idx=%0d last=%0b",
                 out_valid, out_re, out_im, out_index, out_last, prev_re, prev_im, prev_idx, prev_last);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_re = out_re;
    prev_im = out_im;
    prev_idx = out_index;
    prev_last = out_last;
    if (out_valid && out_ready) begin
      n_vec++;
      if (q_re.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: output re=%0d presented, required no output", out_re);
      end else begin
        e_re = q_re.pop_front();
        e_im = q_im.pop_front();
        e_idx = q_idx.pop_front();
        e_last = (out_pos == NP - 1);
        if (out_re !== e_re || out_im !== e_im || out_index !== 3'(e_idx) || out_last !== e_last) begin
          n_err++;
          $display("FAIL sb_data: re=%0d im=%0d idx=%0d last=%0b, required re=%0d im=%0d idx=%0d last=%0b",
                   out_re, out_im, out_index, out_last, e_re, e_im, e_idx, e_last);
        end
        out_pos = (out_pos + 1) % NP;
        out_count++;
      end
    end
    if (in_valid && in_ready) begin
      fr_re[fill] = in_re;
      fr_im[fill] = in_im;
      fill++;
      if (fill == NP) begin
        for (int k = 0; k < NP; k++) begin
          q_re.push_back(fr_re[perm[k]]);
          q_im.push_back(fr_im[perm[k]]);
          q_idx.push_back(perm[k]);
        end
        fill = 0;
      end
    end
  endtask

  task automatic tick(input logic v, input int re, input logic rdy);
    @(negedge clk);
    in_valid = v;
    in_re = DW'(re);
    in_im = -DW'(re);
    out_ready = rdy;
    #1;
    sb_sample();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    arst_n = 1'b0;
    sb_clear();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    int sent;
    int cyc;
`ifdef FFT_REORDER_BITREV_EN
    perm = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    perm = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    sb_clear();

    // Single frame: fill 8 cycles, then drain 8 cycles, then idle.
    for (int c = 0; c < 17; c++) begin
      tbl[c].in_valid      = (c < 8);
      tbl[c].in_re         = (c < 8) ? DW'(c) : '0;
      tbl[c].out_ready     = 1'b1;
      tbl[c].exp_in_ready  = 1'b1;
      tbl[c].exp_out_valid = (c >= 8 && c < 16);
      tbl[c].exp_re        = (c >= 8 && c < 16) ? DW'(perm[c-8]) : '0;
      tbl[c].exp_idx       = (c >= 8 && c < 16) ? 3'(perm[c-8]) : 3'd0;
      tbl[c].exp_last      = (c == 15);
    end

    do_reset();
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_last", int'(out_last), 0);
    chk("reset_out_index", int'(out_index), 0);
    chk("reset_out_re", int'(out_re), 0);
    chk("reset_out_im", int'(out_im), 0);

    for (int r = 0; r < 17; r++) begin
      tick(tbl[r].in_valid, int'(tbl[r].in_re), tbl[r].out_ready);
      n_vec++;
      if (in_ready !== tbl[r].exp_in_ready || out_valid !== tbl[r].exp_out_valid ||
          out_re !== tbl[r].exp_re || out_im !== -tbl[r].exp_re ||
          out_index !== tbl[r].exp_idx || out_last !== tbl[r].exp_last) begin
        n_err++;
        $display("FAIL table[%0d]: rdy=%0b vld=%0b re=%0d im=%0d idx=%0d last=%0b, required rdy=%0b vld=%0b re=%0d im=%0d idx=%0d last=%0b",
                 r, in_ready, out_valid, out_re, out_im, out_index, out_last,
                 tbl[r].exp_in_ready, tbl[r].exp_out_valid, tbl[r].exp_re, -tbl[r].exp_re,
                 tbl[r].exp_idx, tbl[r].exp_last);
      end
    end

    // Four back-to-back frames, sink always ready.
    do_reset();
    for (int c = 0; c < 32; c++) begin
      tick(1'b1, c, 1'b1);
      chk($sformatf("stream_in_ready[%0d]", c), int'(in_ready), 1);
    end
    cyc = 0;
    while (q_re.size() != 0 && cyc < 20) begin
      tick(1'b0, 0, 1'b1);
      cyc++;
    end
    chk("stream_out_count", out_count, 32);

    // Back-pressure: both banks fill, 17th sample is held.
    do_reset();
    sent = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 100 + sent, 1'b0);
      chk($sformatf("bp_in_ready[%0d]", i), int'(in_ready), (i < 16) ? 1 : 0);
      if (in_ready) sent++;
    end
    for (int d = 0; d < 9; d++) begin
      tick(1'b1, 100 + sent, 1'b1);
      chk($sformatf("bp_release_in_ready[%0d]", d), int'(in_ready), (d == 8) ? 1 : 0);
      if (d == 7) chk("bp_frame0_last", int'(out_last), 1);
      if (in_ready) sent++;
    end
    cyc = 0;
    while (sent < 24 && cyc < 100) begin
      tick(1'b1, 100 + sent, 1'b1);
      if (in_ready) sent++;
      cyc++;
    end
    cyc = 0;
    while (q_re.size() != 0 && cyc < 50) begin
      tick(1'b0, 0, 1'b1);
      cyc++;
    end
    chk("bp_sent", sent, 24);
    chk("bp_out_count", out_count, 24);

    // Random sink stalls during streaming and draining.
    do_reset();
    sent = 0;
    cyc = 0;
    while ((sent < 24 || q_re.size() != 0) && cyc < 400) begin
      tick(sent < 24, 300 + sent, 1'($urandom_range(0, 1)));
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("rand_sent", sent, 24);
    chk("rand_out_count", out_count, 24);

    // Asynchronous reset while frame 0 drains and frame 1 is partial.
    do_reset();
    sent = 0;
    cyc = 0;
    while (sent < 13 && cyc < 30) begin
      tick(1'b1, 50 + sent, 1'b0);
      if (in_ready) sent++;
      cyc++;
    end
    for (int d = 0; d < 3; d++) tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b0);
    chk("arst_pre_out_valid", int'(out_valid), 1);
    #1;
    arst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_re", int'(out_re), 0);
    chk("arst_out_index", int'(out_index), 0);
    sb_clear();
    @(negedge clk);
    arst_n = 1'b1;
    for (int c = 0; c < 8; c++) tick(1'b1, 200 + c, 1'b1);
    cyc = 0;
    while (q_re.size() != 0 && cyc < 20) begin
      tick(1'b0, 0, 1'b1);
      cyc++;
    end
    chk("arst_out_count", out_count, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
